// File: rtl/tag_ram_pkg.sv
// ---------------------------------------------------------------------------
// tag_ram_pkg
// Shared definitions for the tag RAM controller of the direct-mapped cache:
//   - default geometry (index width, tag width, statistics counter width)
//   - controller state encoding
//   - arbiter side numbering (which request bit belongs to which port)
//   - helpers to build and test a tag RAM entry {valid, tag}
// ---------------------------------------------------------------------------
package tag_ram_pkg;

  localparam int DEF_AWIDTH = 3;
  localparam int DEF_TWIDTH = 13;
  localparam int DEF_CWIDTH = 16;
  localparam int DEF_DWIDTH = DEF_TWIDTH + 1;

  // The valid flag sits just above the tag in every RAM word.
  localparam int VALID_BIT = DEF_TWIDTH;

  // Arbiter request/grant bit positions.
  localparam int SIDE_LK = 0;
  localparam int SIDE_FL = 1;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_CMP
  } state_t;

  typedef logic [DEF_DWIDTH-1:0] entry_t;

  function automatic entry_t make_entry(input logic valid,
                                        input logic [DEF_TWIDTH-1:0] tag);
    return {valid, tag};
  endfunction

  function automatic logic entry_hit(input entry_t entry,
                                     input logic [DEF_TWIDTH-1:0] tag);
    return entry[VALID_BIT] && (entry[DEF_TWIDTH-1:0] == tag);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter.
// Ports:
//   clock    in   single clock
//   reset_n  in   asynchronous active-low reset (req[0] favoured after reset)
//   req      in   [1:0] request vector
//   advance  in   the grant is actually consumed this cycle
//   gnt      out  [1:0] one-hot grant (zero when no request)
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // prio_q = 0 favours req[0] on a tie, 1 favours req[1].
  logic prio_q;

  // Only a contended, consumed grant moves the pointer; a lone requester
  // never steals the other side's turn.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prio_q <= 1'b0;
    end else if (advance && (&req)) begin
      prio_q <= ~prio_q;
    end
  end

  always_comb begin
    gnt = 2'b00;
    if (&req) begin
      gnt = prio_q ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/tag_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tag_ram_ctrl
// Sequencer/arbiter for one synchronous-read tag RAM bank. Sweeps the bank
// to invalid after reset or flush, arbitrates lookups against fills, and
// keeps saturating hit/miss statistics.
// Ports:
//   clock, reset_n              clock, asynchronous active-low reset
//   flush                       restart the invalidate sweep (IDLE only)
//   lk_req/lk_index/lk_tag      lookup request; lk_ready = accepted
//   lk_done/lk_hit              lookup result, one cycle after acceptance
//   fl_req/fl_index/fl_tag/fl_valid  fill/invalidate; fl_ready = written
//   ram_addr/ram_din/ram_we     to the tag RAM macro
//   ram_dout                    from the RAM, valid the cycle after addr
//   init_done                   high while the bank is usable
//   hit_cnt/miss_cnt            saturating statistics
// ---------------------------------------------------------------------------
module tag_ram_ctrl
  import tag_ram_pkg::*;
#(
  parameter int AWIDTH = DEF_AWIDTH,
  parameter int TWIDTH = DEF_TWIDTH,
  parameter int CWIDTH = DEF_CWIDTH
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              lk_req,
  input  logic [AWIDTH-1:0] lk_index,
  input  logic [TWIDTH-1:0] lk_tag,
  output logic              lk_ready,
  output logic              lk_done,
  output logic              lk_hit,
  input  logic              fl_req,
  input  logic [AWIDTH-1:0] fl_index,
  input  logic [TWIDTH-1:0] fl_tag,
  input  logic              fl_valid,
  output logic              fl_ready,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [TWIDTH:0]   ram_din,
  output logic              ram_we,
  input  logic [TWIDTH:0]   ram_dout,
  output logic              init_done,
  output logic [CWIDTH-1:0] hit_cnt,
  output logic [CWIDTH-1:0] miss_cnt
);

  localparam logic [AWIDTH-1:0] LAST_INDEX = '1;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] ptr_q;
  logic [TWIDTH-1:0] tag_q;
  logic              grant_en;
  logic [1:0]        arb_req;
  logic [1:0]        gnt;

  // Grants are only possible in IDLE, and flush pre-empts both requesters.
  assign grant_en = (state_q == ST_IDLE) && !flush;
  assign arb_req  = grant_en ? {fl_req, lk_req} : 2'b00;

  rr_arb2 u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (arb_req),
    .advance (grant_en),
    .gnt     (gnt)
  );

  always_comb begin
    state_d   = state_q;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_din   = '0;
    lk_ready  = 1'b0;
    fl_ready  = 1'b0;
    lk_done   = 1'b0;
    lk_hit    = 1'b0;
    init_done = 1'b0;
    case (state_q)
      ST_INIT: begin
        // Reset parks the FSM in INIT; gating with reset_n keeps the RAM
        // write strobe low for as long as reset is held.
        ram_we   = reset_n;
        ram_addr = ptr_q;
        if (ptr_q == LAST_INDEX) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        init_done = 1'b1;
        if (flush) begin
          state_d = ST_INIT;
        end else if (gnt[SIDE_FL]) begin
          ram_we   = 1'b1;
          ram_addr = fl_index;
          ram_din  = {fl_valid, fl_tag};
          fl_ready = 1'b1;
        end else if (gnt[SIDE_LK]) begin
          ram_addr = lk_index;
          lk_ready = 1'b1;
          state_d  = ST_CMP;
        end
      end
      ST_CMP: begin
        init_done = 1'b1;
        lk_done   = 1'b1;
        lk_hit    = ram_dout[TWIDTH] && (ram_dout[TWIDTH-1:0] == tag_q);
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) begin
        ptr_q <= ptr_q + AWIDTH'(1);
      end else if (state_q == ST_IDLE && flush) begin
        ptr_q <= '0;
      end
      if (lk_ready) begin
        tag_q <= lk_tag;
      end
    end
  end

  // Statistics survive flush; only reset clears them. Each counter holds
  // at all-ones instead of wrapping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (lk_done) begin
      if (lk_hit) begin
        if (hit_cnt != '1) begin
          hit_cnt <= hit_cnt + CWIDTH'(1);
        end
      end else if (miss_cnt != '1) begin
        miss_cnt <= miss_cnt + CWIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_tag_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tag_ram_ctrl
// Directed bench for tag_ram_ctrl with a behavioural synchronous-read tag
// RAM. A second, narrow-counter instance fed by a constant RAM word
// exercises counter saturation.
// ---------------------------------------------------------------------------
module tb_tag_ram_ctrl;
  import tag_ram_pkg::*;

  logic                  clock = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  flush = 1'b0;
  logic                  lk_req = 1'b0;
  logic [DEF_AWIDTH-1:0] lk_index = '0;
  logic [DEF_TWIDTH-1:0] lk_tag = '0;
  logic                  lk_ready, lk_done, lk_hit;
  logic                  fl_req = 1'b0;
  logic [DEF_AWIDTH-1:0] fl_index = '0;
  logic [DEF_TWIDTH-1:0] fl_tag = '0;
  logic                  fl_valid = 1'b0;
  logic                  fl_ready;
  logic [DEF_AWIDTH-1:0] ram_addr;
  logic [DEF_DWIDTH-1:0] ram_din;
  logic                  ram_we;
  logic [DEF_DWIDTH-1:0] ram_dout;
  logic                  init_done;
  logic [DEF_CWIDTH-1:0] hit_cnt, miss_cnt;

  // Narrow-counter instance
  logic                  s_lk_req = 1'b0;
  logic [DEF_TWIDTH-1:0] s_lk_tag = 13'h0042;
  logic [DEF_DWIDTH-1:0] s_ram_dout = 14'h2042;
  logic                  s_lk_ready, s_lk_done, s_lk_hit, s_fl_ready;
  logic [DEF_AWIDTH-1:0] s_ram_addr;
  logic [DEF_DWIDTH-1:0] s_ram_din;
  logic                  s_ram_we, s_init_done;
  logic [3:0]            s_hit_cnt, s_miss_cnt;

  logic [DEF_DWIDTH-1:0] mem [1 << DEF_AWIDTH];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  always_ff @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  tag_ram_ctrl dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .lk_req(lk_req), .lk_index(lk_index), .lk_tag(lk_tag),
    .lk_ready(lk_ready), .lk_done(lk_done), .lk_hit(lk_hit),
    .fl_req(fl_req), .fl_index(fl_index), .fl_tag(fl_tag),
    .fl_valid(fl_valid), .fl_ready(fl_ready),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout), .init_done(init_done),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  tag_ram_ctrl #(.CWIDTH(4)) dut_sat (
    .clock(clock), .reset_n(reset_n), .flush(1'b0),
    .lk_req(s_lk_req), .lk_index(3'd0), .lk_tag(s_lk_tag),
    .lk_ready(s_lk_ready), .lk_done(s_lk_done), .lk_hit(s_lk_hit),
    .fl_req(1'b0), .fl_index(3'd0), .fl_tag(13'h0), .fl_valid(1'b0),
    .fl_ready(s_fl_ready),
    .ram_addr(s_ram_addr), .ram_din(s_ram_din), .ram_we(s_ram_we),
    .ram_dout(s_ram_dout), .init_done(s_init_done),
    .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt)
  );

  task automatic do_lookup(input logic [DEF_AWIDTH-1:0] idx,
                           input logic [DEF_TWIDTH-1:0] tag,
                           output logic done, output logic hit);
    int n;
    lk_req = 1'b1; lk_index = idx; lk_tag = tag;
    #1;
    n = 0;
    while (lk_ready !== 1'b1 && n < 20) begin
      @(negedge clock); #1; n++;
    end
    checks++;
    if (lk_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lookup_grant_timeout: lk_ready=%b, want 1 within 20 cycles", lk_ready);
    end
    @(negedge clock);
    lk_req = 1'b0;
    #1;
    done = lk_done;
    hit  = lk_hit;
  endtask

  task automatic do_fill(input logic [DEF_AWIDTH-1:0] idx,
                         input logic [DEF_TWIDTH-1:0] tag, input logic valid);
    int n;
    fl_req = 1'b1; fl_index = idx; fl_tag = tag; fl_valid = valid;
    #1;
    n = 0;
    while (fl_ready !== 1'b1 && n < 20) begin
      @(negedge clock); #1; n++;
    end
    checks++;
    if (fl_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fill_grant_timeout: fl_ready=%b, want 1 within 20 cycles", fl_ready);
    end
    @(negedge clock);
    fl_req = 1'b0;
  endtask

  task automatic test_reset;
    lk_req = 1'b1; fl_req = 1'b1;
    #1;
    checks++;
    if ({ram_we, lk_ready, fl_ready, lk_done, lk_hit, init_done} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: we,lkr,flr,done,hit,init=%b, want 000000",
               {ram_we, lk_ready, fl_ready, lk_done, lk_hit, init_done});
    end
    checks++;
    if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_counters: hit=%h miss=%h, want 0 0", hit_cnt, miss_cnt);
    end
    lk_req = 1'b0; fl_req = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_init_sweep(input string name);
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if ({ram_we, ram_addr, ram_din, init_done} !== {1'b1, 3'(i), 14'h0, 1'b0}) begin
        errors++;
        $display("[TB] FAIL %s[%0d]: we=%b addr=%0d din=%h init=%b, want we=1 addr=%0d din=0 init=0",
                 name, i, ram_we, ram_addr, ram_din, init_done, i);
      end
      @(negedge clock);
    end
    #1;
    checks++;
    if (init_done !== 1'b1 || ram_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_end: init=%b we=%b, want init=1 we=0", name, init_done, ram_we);
    end
  endtask

  task automatic test_fill_lookup;
    logic d, h;
    fl_req = 1'b1; fl_index = 3'd3; fl_tag = 13'h0A5; fl_valid = 1'b1;
    #1;
    checks++;
    if ({fl_ready, ram_we, ram_addr, ram_din} !== {1'b1, 1'b1, 3'd3, make_entry(1'b1, 13'h0A5)}) begin
      errors++;
      $display("[TB] FAIL fill_write: flr=%b we=%b addr=%0d din=%h, want 1 1 3 20a5",
               fl_ready, ram_we, ram_addr, ram_din);
    end
    @(negedge clock);
    fl_req = 1'b0;
    do_lookup(3'd3, 13'h0A5, d, h);
    checks++;
    if ({d, h} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL lookup_hit: done,hit=%b%b, want 11", d, h);
    end
    do_lookup(3'd3, 13'h0A6, d, h);
    checks++;
    if ({d, h} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL lookup_tag_miss: done,hit=%b%b, want 10", d, h);
    end
    @(negedge clock); #1;
    checks++;
    if (hit_cnt !== 16'd1 || miss_cnt !== 16'd1) begin
      errors++;
      $display("[TB] FAIL counters_after_fill: hit=%0d miss=%0d, want 1 1", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_back_to_back;
    // {lk_ready, fl_ready, lk_done, lk_hit} per cycle with both requests held
    logic [3:0] exp [6];
    exp = '{4'b1000, 4'b0011, 4'b0100, 4'b1000, 4'b0011, 4'b0100};
    lk_req = 1'b1; lk_index = 3'd3; lk_tag = 13'h0A5;
    fl_req = 1'b1; fl_index = 3'd6; fl_tag = 13'h111; fl_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if ({lk_ready, fl_ready, lk_done, lk_hit} !== exp[c]) begin
        errors++;
        $display("[TB] FAIL rr_cycle[%0d]: lkr,flr,done,hit=%b, want %b",
                 c, {lk_ready, fl_ready, lk_done, lk_hit}, exp[c]);
      end
      @(negedge clock);
    end
    lk_req = 1'b0; fl_req = 1'b0;
  endtask

  task automatic test_invalidate;
    logic d, h;
    do_fill(3'd5, 13'h0C3, 1'b1);
    do_lookup(3'd5, 13'h0C3, d, h);
    checks++;
    if ({d, h} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL write_then_read: done,hit=%b%b, want 11", d, h);
    end
    do_fill(3'd5, 13'h0C3, 1'b0);
    do_lookup(3'd5, 13'h0C3, d, h);
    checks++;
    if ({d, h} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL invalidated_entry: done,hit=%b%b, want 10", d, h);
    end
    do_lookup(3'd6, 13'h111, d, h);
    checks++;
    if ({d, h} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL contended_fill_data: done,hit=%b%b, want 11", d, h);
    end
    @(negedge clock); #1;
    checks++;
    if (hit_cnt !== 16'd5 || miss_cnt !== 16'd2) begin
      errors++;
      $display("[TB] FAIL counters_after_inval: hit=%0d miss=%0d, want 5 2", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_flush;
    logic d, h;
    logic [DEF_AWIDTH-1:0] idx [3];
    logic [DEF_TWIDTH-1:0] tg [3];
    idx = '{3'd3, 3'd5, 3'd6};
    tg  = '{13'h0A5, 13'h0C3, 13'h111};
    flush = 1'b1; lk_req = 1'b1; lk_index = 3'd3; lk_tag = 13'h0A5;
    #1;
    checks++;
    if (lk_ready !== 1'b0 || fl_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_blocks_grant: lkr=%b flr=%b, want 0 0", lk_ready, fl_ready);
    end
    @(negedge clock);
    flush = 1'b0; lk_req = 1'b0;
    test_init_sweep("flush_sweep");
    for (int k = 0; k < 3; k++) begin
      do_lookup(idx[k], tg[k], d, h);
      checks++;
      if ({d, h} !== 2'b10) begin
        errors++;
        $display("[TB] FAIL post_flush_miss[%0d]: done,hit=%b%b, want 10", idx[k], d, h);
      end
    end
    @(negedge clock); #1;
    checks++;
    if (hit_cnt !== 16'd5 || miss_cnt !== 16'd5) begin
      errors++;
      $display("[TB] FAIL counters_kept_on_flush: hit=%0d miss=%0d, want 5 5", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_saturation;
    int pulses = 0;
    int cycles = 0;
    s_lk_req = 1'b1;
    while (pulses < 14 && cycles < 200) begin
      @(negedge clock); #1; cycles++;
      if (s_lk_done === 1'b1) pulses++;
    end
    @(negedge clock); #1;
    checks++;
    if (s_hit_cnt !== 4'hE) begin
      errors++;
      $display("[TB] FAIL sat_before_top: hit=%h, want e (pulses=%0d)", s_hit_cnt, pulses);
    end
    while (pulses < 20 && cycles < 200) begin
      @(negedge clock); #1; cycles++;
      if (s_lk_done === 1'b1) pulses++;
    end
    s_lk_req = 1'b0;
    @(negedge clock); #1;
    checks++;
    if (s_hit_cnt !== 4'hF || s_miss_cnt !== 4'h0) begin
      errors++;
      $display("[TB] FAIL sat_hold: hit=%h miss=%h, want f 0 (pulses=%0d)", s_hit_cnt, s_miss_cnt, pulses);
    end
  endtask

  task automatic test_reset_midop;
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 3'd3) begin
      errors++;
      $display("[TB] FAIL midsweep_addr: we=%b addr=%0d, want 1 3", ram_we, ram_addr);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({ram_we, ram_addr, init_done, lk_done, lk_ready, fl_ready} !== 8'b0) begin
      errors++;
      $display("[TB] FAIL reset_midsweep: we=%b addr=%0d init=%b done=%b, want all 0",
               ram_we, ram_addr, init_done, lk_done);
    end
    @(negedge clock);
    reset_n = 1'b1;
    test_init_sweep("restart_sweep");
    checks++;
    if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_clears_counters: hit=%0d miss=%0d, want 0 0", hit_cnt, miss_cnt);
    end
    lk_req = 1'b1; lk_index = 3'd2; lk_tag = 13'h001;
    #1;
    @(negedge clock);
    lk_req = 1'b0;
    #1;
    checks++;
    if (lk_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL cmp_reached: lk_done=%b, want 1", lk_done);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({lk_done, lk_hit, ram_we, init_done} !== 4'b0) begin
      errors++;
      $display("[TB] FAIL reset_in_cmp: done,hit,we,init=%b, want 0000",
               {lk_done, lk_hit, ram_we, init_done});
    end
    @(negedge clock);
    reset_n = 1'b1;
    test_init_sweep("cmp_reset_sweep");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_init_sweep("init_sweep");
    test_fill_lookup();
    test_back_to_back();
    test_invalidate();
    test_flush();
    test_saturation();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
